// File: rtl/ex_md_pkg.sv
// ex_md_pkg: shared encodings for the EX-stage HI/LO multiply/divide unit.
//   MD_* : md_op encodings (bit 1 = divide, bit 0 = unsigned)
//   md_state_e : sequencer states S_IDLE/S_BUSY/S_DONE
//   HILO_WR_HI/HILO_WR_LO : bit positions inside hilo_wr
package ex_md_pkg;

   localparam logic [1:0] MD_MULT  = 2'b00;
   localparam logic [1:0] MD_MULTU = 2'b01;
   localparam logic [1:0] MD_DIV   = 2'b10;
   localparam logic [1:0] MD_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } md_state_e;

   localparam int unsigned HILO_WR_HI = 1;
   localparam int unsigned HILO_WR_LO = 0;

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

endpackage

// File: rtl/md_step.sv
// md_step: one radix-2 iteration of the HI/LO datapath, purely combinational.
//   is_div   in  1        0: shift-add multiply step, 1: restoring divide step
//   acc_in   in  WIDTH+1  upper half (partial product / partial remainder)
//   work_in  in  WIDTH    lower half (multiplier bits / dividend-then-quotient bits)
//   operand  in  WIDTH    multiplicand or divisor magnitude
//   acc_out  out WIDTH+1  next upper half
//   work_out out WIDTH    next lower half
// Multiply: {acc,work} is shifted right; after WIDTH steps it holds the 2*WIDTH product.
// Divide: {acc,work} is shifted left; after WIDTH steps work = quotient, acc = remainder.
module md_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH:0]   acc_in,
   input  logic [WIDTH-1:0] work_in,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH:0]   acc_out,
   output logic [WIDTH-1:0] work_out
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;

   always_comb begin
      // acc never exceeds WIDTH significant bits while multiplying, so the sum fits.
      sum      = acc_in + (work_in[0] ? {1'b0, operand} : {(WIDTH + 1){1'b0}});
      shifted  = {acc_in[WIDTH-1:0], work_in[WIDTH-1]};
      // Extra top bit acts as the borrow flag of the trial subtraction.
      diff     = {1'b0, shifted} - {2'b00, operand};
      acc_out  = {1'b0, sum[WIDTH:1]};
      work_out = {sum[0], work_in[WIDTH-1:1]};
      if (is_div) begin
         if (diff[WIDTH+1]) begin
            acc_out  = shifted;
            work_out = {work_in[WIDTH-2:0], 1'b0};
         end else begin
            acc_out  = diff[WIDTH:0];
            work_out = {work_in[WIDTH-2:0], 1'b1};
         end
      end
   end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: EX-stage HI/LO sequencer. Runs MULT/MULTU/DIV/DIVU one bit per cycle on
// operand magnitudes, applies sign fix-up, owns HI/LO and serves MTHI/MTLO.
//   clk, rst            clock, synchronous active-high reset
//   md_start, md_op     mul/div request in EX and its opcode (ex_md_pkg MD_*)
//   md_a, md_b          forwarded rs/rt operands
//   hilo_wr, hilo_wdata MTHI ([1]) / MTLO ([0]) write, honoured only in IDLE
//   flush               kills the EX instruction; aborts a running operation
//   stall               holds PC, IF/ID, ID/EX while an operation is pending
//   busy, done          state == BUSY, state == DONE (one-cycle pulse)
//   hi, lo              architectural HI/LO
// Optional build macro MD_ZERO_SKIP_EN: a zero operand at accept goes straight to DONE.
module ex_muldiv_ctrl
   import ex_md_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             md_start,
   input  logic [1:0]       md_op,
   input  logic [WIDTH-1:0] md_a,
   input  logic [WIDTH-1:0] md_b,
   input  logic [1:0]       hilo_wr,
   input  logic [WIDTH-1:0] hilo_wdata,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   md_state_e        state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             sign_a_q, sign_a_d;
   logic             sign_b_q, sign_b_d;
   logic             b_zero_q, b_zero_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [WIDTH-1:0] mag_b_q, mag_b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   logic             accept;
   logic             in_sign_a, in_sign_b;
   logic [WIDTH:0]   step_acc;
   logic [WIDTH-1:0] step_work;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] quo, rem;

   md_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .is_div   (op_is_div(op_q)),
      .acc_in   (acc_q),
      .work_in  (work_q),
      .operand  (mag_b_q),
      .acc_out  (step_acc),
      .work_out (step_work)
   );

   assign accept    = (state_q == S_IDLE) && md_start && !flush;
   assign in_sign_a = op_is_signed(md_op) & md_a[WIDTH-1];
   assign in_sign_b = op_is_signed(md_op) & md_b[WIDTH-1];

   // Final-iteration results; sign flags are only ever set for signed ops.
   always_comb begin
      prod = {step_acc[WIDTH-1:0], step_work};
      quo  = step_work;
      rem  = step_acc[WIDTH-1:0];
      if (sign_a_q ^ sign_b_q) begin
         prod = -prod;
         quo  = -quo;
      end
      if (sign_a_q) begin
         rem = -rem;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      b_zero_d = b_zero_q;
      a_d      = a_q;
      acc_d    = acc_q;
      work_d   = work_q;
      mag_b_d  = mag_b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d  = S_BUSY;
               cnt_d    = '0;
               op_d     = md_op;
               sign_a_d = in_sign_a;
               sign_b_d = in_sign_b;
               b_zero_d = (md_b == '0);
               a_d      = md_a;
               acc_d    = '0;
               work_d   = in_sign_a ? -md_a : md_a;
               mag_b_d  = in_sign_b ? -md_b : md_b;
`ifdef MD_ZERO_SKIP_EN
               if (md_a == '0 || md_b == '0) begin
                  state_d = S_DONE;
                  if (op_is_div(md_op) && md_b == '0) begin
                     lo_d = '1;
                     hi_d = md_a;
                  end else begin
                     // Zero product, or 0/b giving zero quotient and remainder.
                     lo_d = '0;
                     hi_d = '0;
                  end
               end
`endif
            end else begin
               // A start in the same cycle wins over the MTHI/MTLO write.
               if (hilo_wr[HILO_WR_HI]) begin
                  hi_d = hilo_wdata;
               end
               if (hilo_wr[HILO_WR_LO]) begin
                  lo_d = hilo_wdata;
               end
            end
         end
         S_BUSY: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d  = step_acc;
               work_d = step_work;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  state_d = S_DONE;
                  if (!op_is_div(op_q)) begin
                     hi_d = prod[2*WIDTH-1:WIDTH];
                     lo_d = prod[WIDTH-1:0];
                  end else if (b_zero_q) begin
                     lo_d = '1;
                     hi_d = a_q;
                  end else begin
                     lo_d = quo;
                     hi_d = rem;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         b_zero_q <= 1'b0;
         a_q      <= '0;
         acc_q    <= '0;
         work_q   <= '0;
         mag_b_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         b_zero_q <= b_zero_d;
         a_q      <= a_d;
         acc_q    <= acc_d;
         work_q   <= work_d;
         mag_b_q  <= mag_b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign stall = accept || (state_q == S_BUSY);
   assign busy  = (state_q == S_BUSY);
   assign done  = (state_q == S_DONE);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule
